spi_testgen_param: RTL and testbench
====================================

SPI_TESTGEN_PARAM -- requirements
Module: spi_testgen_param

Interface
REQ-001 Parameter DIV, default 100: sys_clk cycles per spi_clk half-period (DIV >= 1).
REQ-002 Parameter WORD_W, default 16: bits per SPI word.
REQ-003 Parameter N_TX, default 16: words shifted out per run.
REQ-004 Parameter N_RX, default 4: words read back and checked per run.
REQ-005 Parameter LEAD, default 4: idle spi_clk periods before first TX bit; MOSI held 0.
REQ-006 Parameter GAP, default 10: spi_clk periods with spi_en high between TX and RX phases.
REQ-007 sys_clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  single-cycle pulse; begins a run from IDLE.
REQ-010 pat_we  in  1  pattern-memory write strobe.
REQ-011 pat_addr  in  clog2(N_TX+N_RX)  write address; 0..N_TX-1 TX words, N_TX..N_TX+N_RX-1 expected RX words.
REQ-012 pat_wdata  in  WORD_W  pattern word.
REQ-013 spi_out  in  1  serial data returned by the DUT.
REQ-014 spi_in  out  1  serial data to the DUT.
REQ-015 spi_clk_out  out  1  gated SPI clock; toggles only while spi_en is 0.
REQ-016 spi_en  out  1  active-low DUT enable.
REQ-017 busy  out  1  high from start acceptance until DONE.
REQ-018 done  out  1  one-cycle pulse on entering DONE.
REQ-019 led  out  1  pass indicator; high when the last run had zero mismatches.
REQ-020 err_cnt  out  clog2(N_RX+1)  mismatching RX words in the last run.

Function
REQ-021 Internal spi_clk toggles every DIV sys_clk cycles while busy; it rises first after start; phase counter clears on start.
REQ-022 FSM states: IDLE, LEAD, TX, GAP, RX, CHECK, DONE.
REQ-023 IDLE->LEAD on start; LEAD->TX after LEAD rising edges; TX->GAP after N_TX*WORD_W bits; GAP->RX after GAP rising edges; RX->CHECK after N_RX*WORD_W bits; CHECK->DONE after one sys_clk; DONE->IDLE next sys_clk.
REQ-024 spi_en = 0 in TX and RX; 1 in IDLE, LEAD, GAP, CHECK, DONE.
REQ-025 spi_in changes only on spi_clk falling edges; driven MSB-first, word 0 first; 0 outside TX.
REQ-026 spi_out sampled on spi_clk rising edges in RX; shifted in MSB-first into receive word i, i = 0..N_RX-1.
REQ-027 Each completed RX word compared with pattern[N_TX+i]; mismatch increments err_cnt, saturating at N_RX.
REQ-028 In CHECK, led <= (err_cnt == 0); led holds until the next CHECK or reset.
REQ-029 err_cnt clears on start acceptance; holds after DONE.
REQ-030 start while busy ignored; pat_we while busy ignored; pat_we in IDLE writes in one cycle.
REQ-031 pat_we and start in the same IDLE cycle: write completes, run starts, and the run uses the new word.
REQ-032 Bit/word counters wrap to 0 at phase change; no out-of-range pattern access.

Reset
REQ-033 rst asserted: state IDLE, spi_en=1, spi_clk_out=0, spi_in=0, busy=0, done=0, led=0, err_cnt=0, divider and counters cleared, immediately and regardless of phase.
REQ-034 Pattern memory contents are not cleared by rst.
REQ-035 Reset mid-run aborts the run; no done pulse; led not updated.

Structure
REQ-036 Package spi_testgen_pkg holds the FSM state enum and default parameter constants.
REQ-037 Sub-module spi_clkdiv generates the spi_clk level plus one-cycle rise/fall strobes from sys_clk, DIV and enable.

Verification
REQ-038 Defaults, TX words all 16'hFFFF, loopback spi_out=spi_in delayed half period, expected words 16'hFFFF -> led=1, err_cnt=0, done after CHECK.
REQ-039 Expected word 1 = 16'h5554, returned 16'h5555 -> err_cnt=1, led=0.
REQ-040 DIV=1, WORD_W=8, N_TX=2, N_RX=1 -> spi_clk_out period 2 sys_clk; exactly 16 TX falling edges with spi_en=0.
REQ-041 rst asserted during TX bit 7 -> all outputs at reset values the same cycle; later start runs a full, correct sequence.
REQ-042 start re-pulsed during RX and pat_we during GAP -> ignored; memory unchanged, single done pulse.
REQ-043 All N_RX words mismatching -> err_cnt saturates at N_RX (4), led=0.

Source files
------------

// File: rtl/spi_testgen_pkg.sv
// rtl/spi_testgen_pkg.sv - shared FSM states and default parameters for the SPI pattern generator
package spi_testgen_pkg;
    localparam int DEF_DIV    = 100;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_N_TX   = 16;
    localparam int DEF_N_RX   = 4;
    localparam int DEF_LEAD   = 4;
    localparam int DEF_GAP    = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_TX    = 3'd2,
        ST_GAP   = 3'd3,
        ST_RX    = 3'd4,
        ST_CHECK = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/spi_clkdiv.sv
// rtl/spi_clkdiv.sv - spi_clk level plus one-cycle rise/fall strobes, held low while disabled
module spi_clkdiv #(
    parameter int DIV = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic clk_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          tick;

    // Strobes fire in the cycle before the level flips, so they mark the edge itself.
    assign tick   = en_i && (cnt_q == LAST);
    assign rise_o = tick & ~lvl_q;
    assign fall_o = tick & lvl_q;
    assign clk_o  = lvl_q;

    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (!en_i) begin
            cnt_d = '0;
            lvl_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            lvl_d = ~lvl_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end
endmodule

// File: rtl/spi_testgen_param.sv
// rtl/spi_testgen_param.sv - SPI pattern generator: shifts out TX words, reads back and checks RX words
module spi_testgen_param
    import spi_testgen_pkg::*;
#(
    parameter int DIV    = DEF_DIV,
    parameter int WORD_W = DEF_WORD_W,
    parameter int N_TX   = DEF_N_TX,
    parameter int N_RX   = DEF_N_RX,
    parameter int LEAD   = DEF_LEAD,
    parameter int GAP    = DEF_GAP
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pat_we,
    input  logic [$clog2(N_TX+N_RX)-1:0] pat_addr,
    input  logic [WORD_W-1:0]            pat_wdata,
    input  logic                         spi_out,
    output logic                         spi_in,
    output logic                         spi_clk_out,
    output logic                         spi_en,
    output logic                         busy,
    output logic                         done,
    output logic                         led,
    output logic [$clog2(N_RX+1)-1:0]    err_cnt
);
    localparam int AW = $clog2(N_TX + N_RX);
    localparam int EW = $clog2(N_RX + 1);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WW = $clog2(max2(N_TX, N_RX) + 1);
    localparam int CW = $clog2(max2(LEAD, GAP) + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
    localparam logic [WW-1:0] NTX_C    = WW'(N_TX);
    localparam logic [WW-1:0] NRX_C    = WW'(N_RX);
    localparam logic [CW-1:0] LEAD_C   = CW'(LEAD);
    localparam logic [CW-1:0] GAP_C    = CW'(GAP);
    localparam logic [EW-1:0] ERR_MAX  = EW'(N_RX);
    localparam logic [AW-1:0] RX_BASE  = AW'(N_TX);

    logic [WORD_W-1:0] pat_q [2**AW];

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WW-1:0]     word_q, word_d;
    logic [WORD_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic              spi_in_q, spi_in_d, led_q, led_d, done_q, done_d;
    logic [EW-1:0]     err_q, err_d;
    logic              clk_lvl, clk_rise, clk_fall, tx_step;
    logic [AW-1:0]     tx_addr, rx_addr;
    logic [WORD_W-1:0] rx_word;

    spi_clkdiv #(.DIV(DIV)) u_clkdiv (
        .clk_i  (sys_clk),
        .rst_i  (rst),
        .en_i   (busy),
        .clk_o  (clk_lvl),
        .rise_o (clk_rise),
        .fall_o (clk_fall)
    );

    assign busy        = (state_q != ST_IDLE);
    assign spi_en      = !(state_q == ST_TX || state_q == ST_RX);
    assign spi_clk_out = clk_lvl & ~spi_en;
    assign spi_in      = spi_in_q;
    assign done        = done_q;
    assign led         = led_q;
    assign err_cnt     = err_q;
    assign tx_addr     = (word_q < NTX_C) ? AW'(word_q) : '0;
    assign rx_addr     = (word_q < NRX_C) ? RX_BASE + AW'(word_q) : RX_BASE;
    assign rx_word     = {rx_sh_q[WORD_W-2:0], spi_out};

    // Pattern memory survives reset so a board can be re-run without reloading.
    always_ff @(posedge sys_clk) begin
        if (pat_we && !busy) pat_q[pat_addr] <= pat_wdata;
    end

    // TX and RX windows open and close on falling edges so every rising edge the
    // target sees while enabled carries a settled bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        word_d   = word_q;
        tx_sh_d  = tx_sh_q;
        rx_sh_d  = rx_sh_q;
        spi_in_d = spi_in_q;
        err_d    = err_q;
        led_d    = led_q;
        done_d   = 1'b0;
        tx_step  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_LEAD;
                err_d   = '0;
                cnt_d   = '0;
                bit_d   = '0;
                word_d  = '0;
            end
            ST_LEAD: begin
                if (clk_rise) cnt_d = cnt_q + 1'b1;
                if (clk_fall && cnt_q == LEAD_C) begin
                    state_d = ST_TX;
                    cnt_d   = '0;
                    tx_step = 1'b1;
                end
            end
            ST_TX: if (clk_fall) begin
                if (word_q == NTX_C) begin
                    state_d  = ST_GAP;
                    spi_in_d = 1'b0;
                    bit_d    = '0;
                    word_d   = '0;
                end else begin
                    tx_step = 1'b1;
                end
            end
            ST_GAP: begin
                if (clk_rise) cnt_d = cnt_q + 1'b1;
                if (clk_fall && cnt_q == GAP_C) begin
                    state_d = ST_RX;
                    cnt_d   = '0;
                end
            end
            ST_RX: begin
                if (clk_rise) begin
                    rx_sh_d = rx_word;
                    if (bit_q == BIT_LAST) begin
                        bit_d  = '0;
                        word_d = word_q + 1'b1;
                        if (rx_word != pat_q[rx_addr] && err_q != ERR_MAX) err_d = err_q + 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                if (clk_fall && word_q == NRX_C) begin
                    state_d = ST_CHECK;
                    bit_d   = '0;
                    word_d  = '0;
                end
            end
            ST_CHECK: begin
                led_d   = (err_q == '0);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (tx_step) begin
            if (bit_q == '0) begin
                spi_in_d = pat_q[tx_addr][WORD_W-1];
                tx_sh_d  = pat_q[tx_addr] << 1;
            end else begin
                spi_in_d = tx_sh_q[WORD_W-1];
                tx_sh_d  = tx_sh_q << 1;
            end
            if (bit_q == BIT_LAST) begin
                bit_d  = '0;
                word_d = word_q + 1'b1;
            end else begin
                bit_d = bit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            spi_in_q <= 1'b0;
            err_q    <= '0;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
            spi_in_q <= spi_in_d;
            err_q    <= err_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_spi_testgen_param.sv
// tb/tb_spi_testgen_param.sv - directed checks for the SPI pattern generator
module tb_spi_testgen_param;
    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pat_we = 1'b0;
    logic [4:0]  pat_addr = '0;
    logic [15:0] pat_wdata = '0;
    logic        spi_out = 1'b0;
    logic        spi_in, spi_clk_out, spi_en, busy, done, led;
    logic [2:0]  err_cnt;

    logic        s_start = 1'b0;
    logic        s_pat_we = 1'b0;
    logic [1:0]  s_pat_addr = '0;
    logic [7:0]  s_pat_wdata = '0;
    logic        s_spi_out = 1'b1;
    logic        s_spi_in, s_spi_clk_out, s_spi_en, s_busy, s_done, s_led;
    logic [0:0]  s_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    spi_testgen_param #(.DIV(2)) u_dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .pat_we(pat_we), .pat_addr(pat_addr),
        .pat_wdata(pat_wdata), .spi_out(spi_out), .spi_in(spi_in), .spi_clk_out(spi_clk_out),
        .spi_en(spi_en), .busy(busy), .done(done), .led(led), .err_cnt(err_cnt)
    );

    spi_testgen_param #(.DIV(1), .WORD_W(8), .N_TX(2), .N_RX(1)) u_small (
        .sys_clk(sys_clk), .rst(rst), .start(s_start), .pat_we(s_pat_we), .pat_addr(s_pat_addr),
        .pat_wdata(s_pat_wdata), .spi_out(s_spi_out), .spi_in(s_spi_in), .spi_clk_out(s_spi_clk_out),
        .spi_en(s_spi_en), .busy(s_busy), .done(s_done), .led(s_led), .err_cnt(s_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Target model for the main instance: captures TX on rising edges, returns resp[] in RX.
    logic [15:0] resp [4];
    logic [15:0] txcap [16];
    int win = 0, rbit = 0, txbits = 0, done_seen = 0;
    logic prev_en = 1'b1, prev_clk = 1'b0;

    always @(negedge sys_clk) begin
        if (prev_en && !spi_en) begin
            win++;
            if (win == 2) begin
                spi_out = resp[0][15];
                rbit = 1;
            end
        end else if (!spi_en && prev_clk && !spi_clk_out && win == 2 && rbit < 64) begin
            spi_out = resp[rbit / 16][15 - (rbit % 16)];
            rbit++;
        end
        if (!spi_en && !prev_clk && spi_clk_out && win == 1 && txbits < 256) begin
            txcap[txbits / 16][15 - (txbits % 16)] = spi_in;
            txbits++;
        end
        if (done) done_seen++;
        prev_en = spi_en;
        prev_clk = spi_clk_out;
    end

    int s_win = 0, s_falls = 0, s_rises = 0, s_last = 0, s_period = 0, cyc = 0, s_done_seen = 0;
    logic [15:0] s_cap = '0;
    logic sp_en = 1'b1, sp_clk = 1'b0;

    always @(negedge sys_clk) begin
        cyc++;
        if (sp_en && !s_spi_en) s_win++;
        if (s_win == 1 && !sp_en && sp_clk && !s_spi_clk_out) s_falls++;
        if (s_win == 1 && !s_spi_en && !sp_clk && s_spi_clk_out) begin
            s_cap = {s_cap[14:0], s_spi_in};
            if (s_rises > 0) s_period = cyc - s_last;
            s_last = cyc;
            s_rises++;
        end
        if (s_done) s_done_seen++;
        sp_en = s_spi_en;
        sp_clk = s_spi_clk_out;
    end

    task automatic wr(input int a, input logic [15:0] d);
        @(negedge sys_clk);
        pat_we = 1'b1;
        pat_addr = 5'(a);
        pat_wdata = d;
        @(negedge sys_clk);
        pat_we = 1'b0;
    endtask

    task automatic kick();
        @(negedge sys_clk);
        win = 0; rbit = 0; txbits = 0; done_seen = 0;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 4000 && done_seen == 0; i++) @(negedge sys_clk);
        repeat (6) @(negedge sys_clk);
        check({tag, "_done"}, done_seen, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_en"}, spi_en, 1);
        check({tag, "_clk"}, spi_clk_out, 0);
        check({tag, "_in"}, spi_in, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_donep"}, done, 0);
        check({tag, "_led"}, led, 0);
        check({tag, "_err"}, err_cnt, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) resp[i] = 16'hFFFF;
        repeat (3) @(negedge sys_clk);
        check_reset("rst");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) wr(i, 16'hFFFF);
        kick();
        wait_done("t1");
        check("t1_err", err_cnt, 0);
        check("t1_led", led, 1);
        check("t1_txbits", txbits, 256);
        check("t1_tx0", txcap[0], 16'hFFFF);

        for (int i = 0; i < 16; i++) wr(i, 16'hA500 | 16'(i));
        wr(17, 16'h5554);
        resp[1] = 16'h5555;
        kick();
        wait_done("t2");
        check("t2_err", err_cnt, 1);
        check("t2_led", led, 0);
        check("t2_tx0", txcap[0], 16'hA500);
        check("t2_tx9", txcap[9], 16'hA509);
        check("t2_tx15", txcap[15], 16'hA50F);

        for (int i = 16; i < 20; i++) wr(i, 16'h0000);
        resp[0] = 16'hFFFF; resp[1] = 16'h5555; resp[2] = 16'h0F0F; resp[3] = 16'h8001;
        kick();
        wait_done("t3");
        check("t3_err", err_cnt, 4);
        check("t3_led", led, 0);

        for (int i = 0; i < 4; i++) resp[i] = 16'h1234;
        for (int i = 16; i < 20; i++) wr(i, 16'h1234);
        kick();
        for (int i = 0; i < 4000 && txbits < 256; i++) @(negedge sys_clk);
        check("t4_txbits", txbits, 256);
        repeat (6) @(negedge sys_clk);
        check("t4_gap_en", spi_en, 1);
        check("t4_gap_busy", busy, 1);
        wr(16, 16'hDEAD);
        for (int i = 0; i < 4000 && rbit < 20; i++) @(negedge sys_clk);
        check("t4_rx_en", spi_en, 0);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        wait_done("t4");
        check("t4_err", err_cnt, 0);
        check("t4_led", led, 1);
        kick();
        wait_done("t4b");
        check("t4b_err", err_cnt, 0);
        check("t4b_led", led, 1);

        kick();
        for (int i = 0; i < 4000 && txbits < 8; i++) @(negedge sys_clk);
        check("t5_pre_in", spi_in, 1);
        rst = 1'b1;
        #1;
        check_reset("t5_rst");
        @(negedge sys_clk);
        rst = 1'b0;
        kick();
        wait_done("t5");
        check("t5_err", err_cnt, 0);
        check("t5_led", led, 1);
        check("t5_tx7", txcap[7], 16'hA507);

        @(negedge sys_clk);
        win = 0; rbit = 0; txbits = 0; done_seen = 0;
        pat_we = 1'b1; pat_addr = 5'd0; pat_wdata = 16'hC3C3; start = 1'b1;
        @(negedge sys_clk);
        pat_we = 1'b0; start = 1'b0;
        wait_done("t6");
        check("t6_tx0", txcap[0], 16'hC3C3);
        check("t6_tx1", txcap[1], 16'hA501);
        check("t6_err", err_cnt, 0);

        @(negedge sys_clk);
        s_pat_we = 1'b1; s_pat_addr = 2'd0; s_pat_wdata = 8'hA5;
        @(negedge sys_clk);
        s_pat_addr = 2'd1; s_pat_wdata = 8'h3C;
        @(negedge sys_clk);
        s_pat_addr = 2'd2; s_pat_wdata = 8'hFF;
        @(negedge sys_clk);
        s_pat_we = 1'b0; s_start = 1'b1;
        @(negedge sys_clk);
        s_start = 1'b0;
        for (int i = 0; i < 2000 && s_done_seen == 0; i++) @(negedge sys_clk);
        repeat (4) @(negedge sys_clk);
        check("s_done", s_done_seen, 1);
        check("s_err", s_err_cnt, 0);
        check("s_led", s_led, 1);
        check("s_falls", s_falls, 16);
        check("s_rises", s_rises, 16);
        check("s_period", s_period, 2);
        check("s_txword", s_cap, 16'hA53C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
